// File: rtl/puf_pkg.sv
// Shared constants and FSM state type for the arbiter-PUF response demultiplexer.
package puf_pkg;

  localparam int unsigned N_LANES_DEF = 16;
  localparam int unsigned SEL_W_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } demux_state_t;

endpackage

// File: rtl/puf_lane_ctr.sv
// Lane index counter: synchronous clear, count enable, natural wrap at 2**SEL_W.
module puf_lane_ctr #(
  parameter int unsigned SEL_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [SEL_W-1:0] cnt
);

  logic [SEL_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + SEL_W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/puf_resp_demux16.sv
// Serial arbiter bit to 16-lane response demux with valid/ready output.
// Optional resp_parity output enabled by defining PUF_PARITY_EN.
module puf_resp_demux16
  import puf_pkg::*;
#(
  parameter int unsigned N_LANES = N_LANES_DEF,
  localparam int unsigned SEL_W  = $clog2(N_LANES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               auto_sel,
  input  logic [SEL_W-1:0]   se,
  input  logic               bit_in,
  input  logic               bit_valid,
  input  logic               resp_ready,
  output logic [SEL_W-1:0]   sel_out,
  output logic               busy,
  output logic [N_LANES-1:0] resp,
  output logic [N_LANES-1:0] lane_mask,
  output logic               resp_valid,
  output logic               err_dup
`ifdef PUF_PARITY_EN
  ,
  output logic               resp_parity
`endif
);

  demux_state_t       state_q, state_d;
  logic [N_LANES-1:0] resp_q, resp_d;
  logic [N_LANES-1:0] mask_q, mask_d;
  logic               err_q, err_d;
  logic               ctr_clr, ctr_en;
  logic [SEL_W-1:0]   cnt;
  logic [SEL_W-1:0]   lane;

  puf_lane_ctr #(
    .SEL_W (SEL_W)
  ) u_lane_ctr (
    .clk   (clk),
    .reset (reset),
    .clr   (ctr_clr),
    .en    (ctr_en),
    .cnt   (cnt)
  );

  assign lane = auto_sel ? cnt : se;

  always_comb begin
    state_d = state_q;
    resp_d  = resp_q;
    mask_d  = mask_q;
    err_d   = err_q;
    ctr_clr = 1'b0;
    ctr_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COLLECT;
          resp_d  = '0;
          mask_d  = '0;
          err_d   = 1'b0;
          ctr_clr = 1'b1;
        end
      end
      COLLECT: begin
        // Restart takes priority over a coincident bit.
        if (start) begin
          resp_d  = '0;
          mask_d  = '0;
          err_d   = 1'b0;
          ctr_clr = 1'b1;
        end else if (bit_valid) begin
          if (!mask_q[lane]) begin
            resp_d[lane] = bit_in;
            mask_d[lane] = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          ctr_en = auto_sel;
          if (&mask_d) state_d = DONE;
        end
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      resp_q  <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
    end
  end

`ifdef PUF_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (state_q == COLLECT && state_d == DONE) begin
      parity_q <= ^resp_d;
    end
  end

  assign resp_parity = parity_q;
`endif

  assign sel_out    = cnt;
  assign busy       = (state_q == COLLECT);
  assign resp_valid = (state_q == DONE);
  assign resp       = resp_q;
  assign lane_mask  = mask_q;
  assign err_dup    = err_q;

endmodule

// File: tb/tb_puf_resp_demux16.sv
// Directed plus randomized bench for puf_resp_demux16 against a per-lane array model.
module tb_puf_resp_demux16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        auto_sel = 1'b0;
  logic [3:0]  se = 4'd0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        resp_ready = 1'b0;
  logic [3:0]  sel_out;
  logic        busy;
  logic [15:0] resp;
  logic [15:0] lane_mask;
  logic        resp_valid;
  logic        err_dup;
`ifdef PUF_PARITY_EN
  logic        resp_parity;
`endif

  int checks = 0;
  int errors = 0;

  puf_resp_demux16 dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .auto_sel   (auto_sel),
    .se         (se),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .resp_ready (resp_ready),
    .sel_out    (sel_out),
    .busy       (busy),
    .resp       (resp),
    .lane_mask  (lane_mask),
    .resp_valid (resp_valid),
    .err_dup    (err_dup)
`ifdef PUF_PARITY_EN
    ,
    .resp_parity(resp_parity)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 waiting, 1 collecting, 2 presenting.
  int m_phase;
  bit m_written[16];
  bit m_val[16];
  int m_cnt;
  bit m_dup;
  bit m_par;

  function automatic logic [15:0] pack_val();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = m_val[i];
    return v;
  endfunction

  function automatic logic [15:0] pack_written();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = m_written[i];
    return v;
  endfunction

  function automatic bit all_written();
    for (int i = 0; i < 16; i++) if (!m_written[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void clear_collection();
    for (int i = 0; i < 16; i++) begin
      m_written[i] = 1'b0;
      m_val[i]     = 1'b0;
    end
    m_cnt = 0;
    m_dup = 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("sel_out", 32'(sel_out), 32'(m_cnt));
    chk("busy", 32'(busy), 32'(m_phase == 1));
    chk("resp_valid", 32'(resp_valid), 32'(m_phase == 2));
    chk("resp", 32'(resp), 32'(pack_val()));
    chk("lane_mask", 32'(lane_mask), 32'(pack_written()));
    chk("err_dup", 32'(err_dup), 32'(m_dup));
`ifdef PUF_PARITY_EN
    chk("resp_parity", 32'(resp_parity), 32'(m_par));
`endif
  endtask

  // Apply current inputs for one clock, advance the model, then compare.
  task automatic step();
    bit r, st, au, b, bv, rdy;
    int s, lane;
    r = reset; st = start; au = auto_sel; s = int'(se); b = bit_in; bv = bit_valid;
    rdy = resp_ready;
    @(posedge clk);
    if (r) begin
      m_phase = 0;
      clear_collection();
      m_par = 1'b0;
    end else if (m_phase == 0) begin
      if (st) begin
        m_phase = 1;
        clear_collection();
      end
    end else if (m_phase == 1) begin
      if (st) begin
        clear_collection();
      end else if (bv) begin
        lane = au ? m_cnt : s;
        if (m_written[lane]) m_dup = 1'b1;
        else begin
          m_written[lane] = 1'b1;
          m_val[lane]     = b;
        end
        if (au) m_cnt = (m_cnt + 1) % 16;
        if (all_written()) begin
          m_phase = 2;
          m_par   = ^pack_val();
        end
      end
    end else begin
      if (rdy) m_phase = 0;
    end
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    reset = 1'b0; start = 1'b0; bit_valid = 1'b0; resp_ready = 1'b0;
  endtask

  task automatic do_start(input logic au);
    idle_inputs();
    auto_sel = au;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic au, input logic [3:0] s, input logic b);
    auto_sel = au; se = s; bit_in = b; bit_valid = 1'b1;
    step();
    bit_valid = 1'b0;
  endtask

  initial begin
    m_phase = 0;
    clear_collection();
    m_par = 1'b0;

    // Reset state
    reset = 1'b1;
    step();
    step();
    chk("reset_resp", 32'(resp), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);

    // Reset in the middle of a collection
    do_start(1'b1);
    for (int i = 0; i < 5; i++) send(1'b1, 4'd0, 1'($urandom_range(0, 1)));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midreset_mask", 32'(lane_mask), 32'h0);
    chk("midreset_sel", 32'(sel_out), 32'h0);
    chk("midreset_busy", 32'(busy), 32'h0);

    // Auto mode, alternating pattern with lane 0 = 1
    do_start(1'b1);
    for (int i = 0; i < 16; i++) send(1'b1, 4'(15 - i), 1'(i % 2 == 0));
    chk("auto_resp", 32'(resp), 32'h5555);
    chk("auto_valid", 32'(resp_valid), 32'h1);
    chk("auto_dup", 32'(err_dup), 32'h0);
    resp_ready = 1'b1;
    step();

    // External select sweep, only lane 3 carries a 1
    do_start(1'b0);
    for (int i = 15; i >= 0; i--) send(1'b0, 4'(i), 1'(i == 3));
    chk("ext_resp", 32'(resp), 32'h0008);
    chk("ext_mask", 32'(lane_mask), 32'hffff);
    resp_ready = 1'b1;
    step();

    // Duplicate write to lane 2: first write wins
    do_start(1'b0);
    send(1'b0, 4'd2, 1'b1);
    send(1'b0, 4'd2, 1'b0);
    chk("dup_flag", 32'(err_dup), 32'h1);
    chk("dup_lane2", 32'(resp[2]), 32'h1);
    for (int l = 0; l < 16; l++) begin
      if (l == 2) continue;
      if (l == 15) chk("dup_not_done", 32'(resp_valid), 32'h0);
      send(1'b0, 4'(l), 1'($urandom_range(0, 1)));
    end
    chk("dup_done", 32'(resp_valid), 32'h1);

    // Backpressure in DONE
    for (int i = 0; i < 4; i++) begin
      resp_ready = 1'b0;
      start = 1'(i == 1);
      bit_valid = 1'(i == 2);
      step();
      chk("hold_valid", 32'(resp_valid), 32'h1);
    end
    start = 1'b0; bit_valid = 1'b0;
    resp_ready = 1'b1;
    step();
    chk("release_valid", 32'(resp_valid), 32'h0);
    chk("release_busy", 32'(busy), 32'h0);
    resp_ready = 1'b0;

    // Restart together with the 10th bit
    do_start(1'b1);
    for (int i = 0; i < 9; i++) send(1'b1, 4'd0, 1'b1);
    start = 1'b1;
    send(1'b1, 4'd0, 1'b1);
    start = 1'b0;
    chk("restart_mask", 32'(lane_mask), 32'h0);
    chk("restart_cnt", 32'(sel_out), 32'h0);
    chk("restart_busy", 32'(busy), 32'h1);

`ifdef PUF_PARITY_EN
    do_start(1'b0);
    for (int l = 0; l < 16; l++) send(1'b0, 4'(l), 1'(l < 3));
    chk("parity_resp", 32'(resp), 32'h0007);
    chk("parity_bit", 32'(resp_parity), 32'h1);
    resp_ready = 1'b1;
    step();
`endif

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      start      = ($urandom_range(0, 39) == 0);
      auto_sel   = ($urandom_range(0, 3) != 0);
      se         = 4'($urandom_range(0, 15));
      bit_in     = 1'($urandom_range(0, 1));
      bit_valid  = ($urandom_range(0, 4) != 0);
      resp_ready = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
